// File: rtl/vx_warp_sched_rr.sv
// Warp scheduler: tracks per-warp active/stalled/tmask/PC state and issues one
// ready warp per cycle (fixed-priority or round-robin) into a valid/ready register.
//
// state   | meaning
// ST_BOOT | out of reset; next edge loads the boot state of warp 0, no selection
// ST_RUN  | normal scheduling
module vx_warp_sched_rr #(
  parameter int NUM_WARPS      = 8,
  parameter int NUM_THREADS    = 4,
  parameter int PC_WIDTH       = 32,
  parameter int NUM_BRANCH     = 2,
  parameter int POLICY         = 1,
  parameter int PC_INCR        = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NW_WIDTH       = $clog2(NUM_WARPS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [PC_WIDTH-1:0]            startup_pc,
  input  logic                           spawn_valid,
  input  logic [NUM_WARPS-1:0]           spawn_wmask,
  input  logic [PC_WIDTH-1:0]            spawn_pc,
  input  logic                           tmc_valid,
  input  logic [NW_WIDTH-1:0]            tmc_wid,
  input  logic [NUM_THREADS-1:0]         tmc_tmask,
  input  logic [NUM_BRANCH-1:0]          br_valid,
  input  logic [NUM_BRANCH*NW_WIDTH-1:0] br_wid,
  input  logic [NUM_BRANCH-1:0]          br_taken,
  input  logic [NUM_BRANCH*PC_WIDTH-1:0] br_dest,
  input  logic                           unlock_valid,
  input  logic [NW_WIDTH-1:0]            unlock_wid,
  output logic                           sched_valid,
  input  logic                           sched_ready,
  output logic [NW_WIDTH-1:0]            sched_wid,
  output logic [NUM_THREADS-1:0]         sched_tmask,
  output logic [PC_WIDTH-1:0]            sched_pc,
  output logic [NUM_WARPS-1:0]           active_warps,
  output logic                           stall_timeout,
  output logic                           busy
);

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [19:0]         TO_MAX  = 20'(TIMEOUT_CYCLES);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INCR);

  state_t                  r_state, w_state_n;
  logic [NUM_WARPS-1:0]    r_active, r_stalled, w_active_n, w_stalled_n, w_ready;
  logic [NUM_THREADS-1:0]  r_tmask [NUM_WARPS];
  logic [NUM_THREADS-1:0]  w_tmask_n [NUM_WARPS];
  logic [PC_WIDTH-1:0]     r_pc [NUM_WARPS];
  logic [PC_WIDTH-1:0]     w_pc_n [NUM_WARPS];
  logic [NW_WIDTH-1:0]     r_rr_ptr, w_rr_n, w_sel_wid;
  logic                    w_issue;
  logic                    r_out_valid;
  logic [NW_WIDTH-1:0]     r_out_wid;
  logic [NUM_THREADS-1:0]  r_out_tmask;
  logic [PC_WIDTH-1:0]     r_out_pc;
  logic [19:0]             r_to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_BOOT;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    if (r_state == ST_BOOT) w_state_n = ST_RUN;
  end

  assign w_ready = r_active & ~r_stalled;
  assign w_issue = (r_state == ST_RUN) && (|w_ready) && (!r_out_valid || sched_ready);

  // Scan from the far end so the candidate closest to the start point wins.
  always_comb begin
    logic [NW_WIDTH-1:0] v_idx;
    v_idx     = '0;
    w_sel_wid = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (POLICY == 0) v_idx = NW_WIDTH'(i);
      else             v_idx = NW_WIDTH'((int'(r_rr_ptr) + i) % NUM_WARPS);
      if (w_ready[v_idx]) w_sel_wid = v_idx;
    end
  end

  // Per-warp next state; later updates override earlier ones, issue last.
  always_comb begin
    logic [NW_WIDTH-1:0] v_bwid;
    v_bwid      = '0;
    w_active_n  = r_active;
    w_stalled_n = r_stalled;
    w_tmask_n   = r_tmask;
    w_pc_n      = r_pc;
    w_rr_n      = r_rr_ptr;
    if (r_state == ST_BOOT) begin
      w_active_n[0] = 1'b1;
      w_tmask_n[0]  = NUM_THREADS'(1);
      w_pc_n[0]     = startup_pc;
    end else begin
      if (spawn_valid) begin
        for (int i = 0; i < NUM_WARPS; i++) begin
          if (spawn_wmask[i]) begin
            w_active_n[i] = 1'b1;
            w_tmask_n[i]  = NUM_THREADS'(1);
            w_pc_n[i]     = spawn_pc;
          end
        end
      end
      if (tmc_valid) begin
        w_tmask_n[tmc_wid]   = tmc_tmask;
        w_active_n[tmc_wid]  = |tmc_tmask;
        w_stalled_n[tmc_wid] = 1'b0;
      end
      for (int k = 0; k < NUM_BRANCH; k++) begin
        v_bwid = br_wid[k*NW_WIDTH +: NW_WIDTH];
        if (br_valid[k]) begin
          if (br_taken[k]) w_pc_n[v_bwid] = br_dest[k*PC_WIDTH +: PC_WIDTH];
          w_stalled_n[v_bwid] = 1'b0;
        end
      end
      if (unlock_valid) w_stalled_n[unlock_wid] = 1'b0;
      if (w_issue) begin
        w_stalled_n[w_sel_wid] = 1'b1;
        w_pc_n[w_sel_wid]      = r_pc[w_sel_wid] + PC_STEP;
        if (POLICY != 0) begin
          if (w_sel_wid == NW_WIDTH'(NUM_WARPS - 1)) w_rr_n = '0;
          else                                       w_rr_n = w_sel_wid + NW_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active  <= '0;
      r_stalled <= '0;
      r_tmask   <= '{default: '0};
      r_pc      <= '{default: '0};
      r_rr_ptr  <= '0;
    end else begin
      r_active  <= w_active_n;
      r_stalled <= w_stalled_n;
      r_tmask   <= w_tmask_n;
      r_pc      <= w_pc_n;
      r_rr_ptr  <= w_rr_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_wid   <= '0;
      r_out_tmask <= '0;
      r_out_pc    <= '0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_wid   <= w_sel_wid;
      r_out_tmask <= r_tmask[w_sel_wid];
      r_out_pc    <= r_pc[w_sel_wid];
    end else if (sched_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counts only while every active warp is stalled; saturates at the threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_RUN) && (|r_active) && !(|w_ready)) begin
      if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 20'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign sched_valid   = r_out_valid;
  assign sched_wid     = r_out_wid;
  assign sched_tmask   = r_out_tmask;
  assign sched_pc      = r_out_pc;
  assign active_warps  = r_active;
  assign stall_timeout = (r_to_cnt == TO_MAX);
  assign busy          = (|r_active) || r_out_valid;

endmodule

// File: tb/tb_vx_warp_sched_rr.sv
// Directed bench for vx_warp_sched_rr: a round-robin instance and a
// fixed-priority instance share stimulus except for their unlock inputs.
module tb_vx_warp_sched_rr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] startup_pc = 32'h8000_0000;
  logic        spawn_valid = 1'b0;
  logic [7:0]  spawn_wmask = '0;
  logic [31:0] spawn_pc = '0;
  logic        tmc_valid = 1'b0;
  logic [2:0]  tmc_wid = '0;
  logic [3:0]  tmc_tmask = '0;
  logic [1:0]  br_valid = '0;
  logic [5:0]  br_wid = '0;
  logic [1:0]  br_taken = '0;
  logic [63:0] br_dest = '0;
  logic        sched_ready = 1'b1;
  logic        ua_valid = 1'b0, ub_valid = 1'b0;
  logic [2:0]  ua_wid = '0, ub_wid = '0;

  logic        a_valid, a_to, a_busy, b_valid, b_to, b_busy;
  logic [2:0]  a_wid, b_wid;
  logic [3:0]  a_tmask, b_tmask;
  logic [31:0] a_pc, b_pc;
  logic [7:0]  a_active, b_active;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_warp_sched_rr #(.NUM_WARPS(8), .NUM_THREADS(4), .PC_WIDTH(32), .NUM_BRANCH(2),
                     .POLICY(1), .PC_INCR(4), .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .reset_n(reset_n), .startup_pc(startup_pc),
    .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
    .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
    .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
    .unlock_valid(ua_valid), .unlock_wid(ua_wid),
    .sched_valid(a_valid), .sched_ready(sched_ready), .sched_wid(a_wid),
    .sched_tmask(a_tmask), .sched_pc(a_pc), .active_warps(a_active),
    .stall_timeout(a_to), .busy(a_busy));

  vx_warp_sched_rr #(.NUM_WARPS(8), .NUM_THREADS(4), .PC_WIDTH(32), .NUM_BRANCH(2),
                     .POLICY(0), .PC_INCR(4), .TIMEOUT_CYCLES(16)) u_fp (
    .clk(clk), .reset_n(reset_n), .startup_pc(startup_pc),
    .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
    .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
    .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
    .unlock_valid(ub_valid), .unlock_wid(ub_wid),
    .sched_valid(b_valid), .sched_ready(sched_ready), .sched_wid(b_wid),
    .sched_tmask(b_tmask), .sched_pc(b_pc), .active_warps(b_active),
    .stall_timeout(b_to), .busy(b_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    spawn_valid = 1'b0; tmc_valid = 1'b0; br_valid = '0; br_taken = '0;
    ua_valid = 1'b0; ub_valid = 1'b0; sched_ready = 1'b1;
    tick(); tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid_a: got %0h want 0", a_valid); end
    n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid_b: got %0h want 0", b_valid); end
    n_cmp++; if (a_active !== 8'h00) begin n_err++; $display("FAIL rst_active: got %0h want 00", a_active); end
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0h want 0", a_busy); end
    n_cmp++; if (a_to !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %0h want 0", a_to); end
    n_cmp++; if ({a_wid, a_tmask, a_pc} !== 39'd0) begin n_err++; $display("FAIL rst_outregs: got %0h want 0", {a_wid, a_tmask, a_pc}); end
  endtask

  task automatic test_boot();
    do_reset();
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL boot_noissue: got %0h want 0", a_valid); end
    n_cmp++; if (a_active !== 8'h01) begin n_err++; $display("FAIL boot_active: got %0h want 01", a_active); end
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL boot_busy: got %0h want 1", a_busy); end
    tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL boot_issue: got %0h want 1", a_valid); end
    n_cmp++; if (a_wid !== 3'd0) begin n_err++; $display("FAIL boot_wid: got %0d want 0", a_wid); end
    n_cmp++; if (a_tmask !== 4'b0001) begin n_err++; $display("FAIL boot_tmask: got %0h want 1", a_tmask); end
    n_cmp++; if (a_pc !== 32'h8000_0000) begin n_err++; $display("FAIL boot_pc_a: got %0h want 80000000", a_pc); end
    n_cmp++; if (b_pc !== 32'h8000_0000) begin n_err++; $display("FAIL boot_pc_b: got %0h want 80000000", b_pc); end
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL boot_stalled1: got %0h want 0", a_valid); end
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL boot_stalled2: got %0h want 0", a_valid); end
    ua_valid = 1'b1; ua_wid = 3'd0; ub_valid = 1'b1; ub_wid = 3'd0;
    tick();
    ua_valid = 1'b0; ub_valid = 1'b0;
    tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL boot_reissue: got %0h want 1", a_valid); end
    n_cmp++; if (a_pc !== 32'h8000_0004) begin n_err++; $display("FAIL boot_pc_incr_a: got %0h want 80000004", a_pc); end
    n_cmp++; if (b_pc !== 32'h8000_0004) begin n_err++; $display("FAIL boot_pc_incr_b: got %0h want 80000004", b_pc); end
  endtask

  task automatic test_round_robin();
    do_reset();
    tick();
    spawn_valid = 1'b1; spawn_wmask = 8'hFF; spawn_pc = 32'h0000_1000;
    tick();
    spawn_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      n_cmp++; if (a_valid !== 1'b1 || a_wid !== 3'(n % 8)) begin
        n_err++; $display("FAIL rr_seq[%0d]: got valid=%0h wid=%0d want valid=1 wid=%0d", n, a_valid, a_wid, n % 8);
      end
      n_cmp++; if (b_valid !== 1'b1 || b_wid !== 3'(n % 2)) begin
        n_err++; $display("FAIL fp_seq[%0d]: got valid=%0h wid=%0d want valid=1 wid=%0d", n, b_valid, b_wid, n % 2);
      end
      if (n == 1) begin
        n_cmp++; if (a_pc !== 32'h0000_1000) begin n_err++; $display("FAIL rr_spawn_pc: got %0h want 1000", a_pc); end
      end
      if (n == 8) begin
        n_cmp++; if (a_pc !== 32'h8000_0004) begin n_err++; $display("FAIL rr_issue_over_spawn_pc: got %0h want 80000004", a_pc); end
      end
      if (n == 9) begin
        n_cmp++; if (a_pc !== 32'h0000_1004) begin n_err++; $display("FAIL rr_pc_w1: got %0h want 1004", a_pc); end
      end
      ua_valid = 1'b1; ua_wid = a_wid; ub_valid = 1'b1; ub_wid = b_wid;
      tick();
    end
    ua_valid = 1'b0; ub_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    sched_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (a_valid !== 1'b1 || a_pc !== 32'h8000_0000) begin
      n_err++; $display("FAIL bp_first: got valid=%0h pc=%0h want valid=1 pc=80000000", a_valid, a_pc);
    end
    ua_valid = 1'b1; ua_wid = 3'd0; ub_valid = 1'b1; ub_wid = 3'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      ua_valid = 1'b0; ub_valid = 1'b0;
      n_cmp++; if (a_valid !== 1'b1 || a_wid !== 3'd0 || a_pc !== 32'h8000_0000) begin
        n_err++; $display("FAIL bp_hold[%0d]: got valid=%0h wid=%0d pc=%0h want 1/0/80000000", c, a_valid, a_wid, a_pc);
      end
      n_cmp++; if (b_valid !== 1'b1 || b_pc !== 32'h8000_0000) begin
        n_err++; $display("FAIL bp_hold_b[%0d]: got valid=%0h pc=%0h want 1/80000000", c, b_valid, b_pc);
      end
    end
    sched_ready = 1'b1;
    tick();
    n_cmp++; if (a_valid !== 1'b1 || a_pc !== 32'h8000_0004) begin
      n_err++; $display("FAIL bp_release: got valid=%0h pc=%0h want 1/80000004", a_valid, a_pc);
    end
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL bp_stalled: got %0h want 0", a_valid); end
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %0h want 1", a_busy); end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    spawn_valid = 1'b1; spawn_wmask = 8'h0C; spawn_pc = 32'h0000_0040;
    tick();
    spawn_valid = 1'b0;
    tick();
    n_cmp++; if (a_wid !== 3'd2 || a_pc !== 32'h0000_0040) begin
      n_err++; $display("FAIL br_pre_issue: got wid=%0d pc=%0h want 2/40", a_wid, a_pc);
    end
    n_cmp++; if (b_wid !== 3'd2) begin n_err++; $display("FAIL br_pre_issue_b: got %0d want 2", b_wid); end
    sched_ready = 1'b0;
    br_valid = 2'b11; br_taken = 2'b11; br_wid = {3'd2, 3'd2};
    br_dest = {32'h0000_0200, 32'h0000_0100};
    tmc_valid = 1'b1; tmc_wid = 3'd3; tmc_tmask = 4'b0000;
    tick();
    br_valid = '0; br_taken = '0; tmc_valid = 1'b0;
    n_cmp++; if (a_active !== 8'h05) begin n_err++; $display("FAIL br_tmc_active: got %0h want 05", a_active); end
    n_cmp++; if (a_wid !== 3'd2 || a_pc !== 32'h0000_0040) begin
      n_err++; $display("FAIL br_hold: got wid=%0d pc=%0h want 2/40", a_wid, a_pc);
    end
    sched_ready = 1'b1;
    tick();
    n_cmp++; if (a_valid !== 1'b1 || a_wid !== 3'd2 || a_pc !== 32'h0000_0200) begin
      n_err++; $display("FAIL br_collision_a: got valid=%0h wid=%0d pc=%0h want 1/2/200", a_valid, a_wid, a_pc);
    end
    n_cmp++; if (b_valid !== 1'b1 || b_wid !== 3'd2 || b_pc !== 32'h0000_0200) begin
      n_err++; $display("FAIL br_collision_b: got valid=%0h wid=%0d pc=%0h want 1/2/200", b_valid, b_wid, b_pc);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
        n_err++; $display("FAIL br_w3_never[%0d]: got a=%0h/%0d b=%0h/%0d want no issue", c, a_valid, a_wid, b_valid, b_wid);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(); tick();
    for (int c = 0; c < 15; c++) tick();
    n_cmp++; if (a_to !== 1'b0 || b_to !== 1'b0) begin
      n_err++; $display("FAIL to_early: got a=%0h b=%0h want 0/0", a_to, b_to);
    end
    tick();
    n_cmp++; if (a_to !== 1'b1 || b_to !== 1'b1) begin
      n_err++; $display("FAIL to_rise: got a=%0h b=%0h want 1/1", a_to, b_to);
    end
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (a_to !== 1'b1) begin n_err++; $display("FAIL to_hold: got %0h want 1", a_to); end
    ua_valid = 1'b1; ua_wid = 3'd0; ub_valid = 1'b1; ub_wid = 3'd0;
    tick();
    ua_valid = 1'b0; ub_valid = 1'b0;
    tick();
    n_cmp++; if (a_to !== 1'b0 || b_to !== 1'b0) begin
      n_err++; $display("FAIL to_clear: got a=%0h b=%0h want 0/0", a_to, b_to);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sched_ready = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL ar_pending: got %0h want 1", a_valid); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_err++; $display("FAIL ar_valid: got a=%0h b=%0h want 0/0", a_valid, b_valid);
    end
    n_cmp++; if (a_busy !== 1'b0 || a_active !== 8'h00) begin
      n_err++; $display("FAIL ar_busy_active: got busy=%0h active=%0h want 0/00", a_busy, a_active);
    end
    tick(); tick();
    reset_n = 1'b1; sched_ready = 1'b1;
    tick();
    n_cmp++; if (a_valid !== 1'b0 || a_active !== 8'h01) begin
      n_err++; $display("FAIL ar_reboot: got valid=%0h active=%0h want 0/01", a_valid, a_active);
    end
    tick();
    n_cmp++; if (a_valid !== 1'b1 || a_wid !== 3'd0 || a_pc !== 32'h8000_0000) begin
      n_err++; $display("FAIL ar_reissue: got valid=%0h wid=%0d pc=%0h want 1/0/80000000", a_valid, a_wid, a_pc);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_round_robin();
    test_backpressure();
    test_branch();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vx_warp_sched_rr.md
Name: vx_warp_sched_rr

Overview:
- Parametrised warp scheduler for the core front end.
- Tracks per-warp active, stalled, thread-mask and PC state.
- Picks one ready warp per cycle using a selectable policy: fixed-priority or round-robin.
- Presents the pick through a one-entry valid/ready output register to fetch. Adds N branch-resolution channels, a boot sequence and a saturating stall-timeout detector.

Parameters:
- NUM_WARPS, 8, number of warps (>=2).
- NUM_THREADS, 4, threads per warp.
- PC_WIDTH, 32, PC width.
- NUM_BRANCH, 2, branch-resolution channels.
- POLICY, 1, 0 = lowest-index-first; 1 = round-robin.
- PC_INCR, 4, PC advance per issue.
- TIMEOUT_CYCLES, 1000, stall-timeout threshold (<2^20).
- NW_WIDTH, clog2(NUM_WARPS), derived warp-id width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- startup_pc  in  PC_WIDTH  boot PC for warp 0.
- spawn_valid  in  1  warp-spawn request.
- spawn_wmask  in  NUM_WARPS  warps to spawn.
- spawn_pc  in  PC_WIDTH  spawn start PC.
- tmc_valid  in  1  thread-mask change.
- tmc_wid  in  NW_WIDTH  target warp.
- tmc_tmask  in  NUM_THREADS  new mask; zero deactivates the warp.
- br_valid  in  NUM_BRANCH  branch resolved, per channel.
- br_wid  in  NUM_BRANCH*NW_WIDTH  warp id, per channel.
- br_taken  in  NUM_BRANCH  taken flag, per channel.
- br_dest  in  NUM_BRANCH*PC_WIDTH  target PC, per channel.
- unlock_valid  in  1  generic unlock (decode/CSR).
- unlock_wid  in  NW_WIDTH  warp to unlock.
- sched_valid  out  1  output register holds an issue.
- sched_ready  in  1  fetch accepts.
- sched_wid  out  NW_WIDTH  issued warp.
- sched_tmask  out  NUM_THREADS  issued thread mask.
- sched_pc  out  PC_WIDTH  issued PC.
- active_warps  out  NUM_WARPS  active bitmap.
- stall_timeout  out  1  all active warps stalled for TIMEOUT_CYCLES.
- busy  out  1  active_warps!=0 or sched_valid.

Behaviour:
- Reset (async assert, sync release): all state zero, boot=1, rr_ptr=0.
  - Outputs: sched_valid=0, sched_wid/tmask/pc=0, active_warps=0, stall_timeout=0, busy=0.
- Boot: in the first clk edge with reset_n=1 and boot=1:
  - pc[0]<=startup_pc, tmask[0]<=1, active[0]<=1, boot<=0.
  - No selection occurs while boot=1.
- ready = active & ~stalled.
- Selection, combinational:
  - POLICY 0: lowest set bit of ready.
  - POLICY 1: first set bit at or after rr_ptr, wrapping from NUM_WARPS-1 to 0.
- Issue fires when ready!=0 && (!sched_valid || sched_ready).
  - Output register loads {tmask, pc, wid} of the selected warp.
  - stalled[wid]<=1.
  - pc[wid]<=pc[wid]+PC_INCR, modulo 2^PC_WIDTH.
  - POLICY 1: rr_ptr<=wid+1, wrapping to 0.
- Output handshake:
  - sched_valid drops after sched_ready with no new issue.
  - Output is held stable while sched_valid && !sched_ready.
  - Issue-to-output latency is 1 cycle; back-to-back issue at one per cycle is supported.
- State update order, later wins per field: spawn, tmc, branch channels 0..NUM_BRANCH-1, unlock, issue.
  - spawn: active|=spawn_wmask; for each set bit, tmask[i]<=1 and pc[i]<=spawn_pc.
  - tmc: tmask[tmc_wid]<=tmc_tmask; active[tmc_wid]<=(tmc_tmask!=0); stalled[tmc_wid]<=0.
  - branch channel k: if br_taken, pc[br_wid]<=br_dest; stalled[br_wid]<=0. Two channels hitting the same warp: the higher k wins the PC.
  - unlock: stalled[unlock_wid]<=0.
  - issue: applied last. It overrides any same-cycle update to the issued warp's stall bit and PC.
- Deactivated warps keep their stall bit but are never selected.
- Timeout counter (20 bits):
  - Increments while boot=0, active!=0 and (active & ~stalled)==0.
  - Otherwise clears to 0.
  - Saturates at TIMEOUT_CYCLES.
  - stall_timeout = (count==TIMEOUT_CYCLES).
- Reset mid-operation: everything returns to reset values asynchronously. A pending output is dropped; the boot sequence repeats.

Test Plan:
1. Boot: reset_n low 3 cycles, startup_pc=0x8000_0000, sched_ready=1. Required: cycle 1 after release has no issue; cycle 2 issues wid=0, tmask=0001, pc=0x8000_0000; pc[0] becomes 0x8000_0004; no further issue until an unlock.
2. Round-robin: POLICY=1, spawn_wmask=0xFF, unlock every issued warp the next cycle. Required: wid sequence 0,1,...,7,0 with no repeats inside a window of 8. With POLICY=0 under the same stimulus, the sequence repeats 0,1,0,1.
3. Backpressure: sched_ready=0 for 5 cycles with warp 0 ready. Required: sched_valid=1 and wid/pc stable for all 5 cycles; exactly one issue; warp 0 stalled.
4. Branch collision: br_valid=11, both channels target wid=2, br_dest 0x100 and 0x200, both taken. Required: pc[2]=0x200 and warp 2 unstalled. Same-cycle tmc with tmask=0 on wid=3: warp 3 inactive and never issued.
5. Timeout: TIMEOUT_CYCLES=16, one active warp issued and never unlocked. Required: stall_timeout rises exactly 16 cycles after the stall begins and holds; an unlock clears it the next cycle.
6. Async reset: assert reset_n mid-backpressure. Required: sched_valid, busy and active_warps drop with no clock edge needed; the boot repeats after release.
